sseg_scan_driver: RTL and testbench

Time-multiplexes four 8-bit segment patterns from the character ROMs onto the shared 4-digit seven-segment display. It sits directly downstream of the character_rom instances, in the scan stage position.
- Adds tear-free frame-synchronous pattern update, per-digit blink and 8-level brightness.
- Emits a frame tick that upstream logic can use as a slow enable.

---
 rtl/sseg_scan_driver.sv | 120 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - four-digit seven-segment scan driver with frame-synced update, blink and brightness
//
// Purpose: time-multiplexes four active-low segment bytes onto a shared
// 4-digit display. Patterns are staged in a shadow register and promoted
// to the displayed (active) register only at frame boundaries.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   sseg_in    - [31:24] leftmost digit (anode[3]) .. [7:0] rightmost (anode[0])
//   load       - capture sseg_in into the shadow register this cycle
//   blink_mask - bit i set -> digit i blinks
//   bright     - on-time is (bright+1)/8 of each digit slot
//   anode      - active-low digit enables (registered)
//   sout       - active-low segment pattern (registered)
//   frame_tick - one-cycle pulse after each frame boundary (registered)
module sseg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sseg_in,
  input  logic        load,
  input  logic [3:0]  blink_mask,
  input  logic [2:0]  bright,
  output logic [3:0]  anode,
  output logic [7:0]  sout,
  output logic        frame_tick
);

  localparam int SW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Wide enough that 8*SUB (== REFRESH_DIV) never overflows.
  localparam int PW  = SW + 4;
  localparam int SUB = REFRESH_DIV / 8;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] SUB_P      = PW'(SUB);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   active_q, active_d;
  logic [3:0]    anode_q, anode_d;
  logic [7:0]    sout_q, sout_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_wrap;
  logic          frame_end;
  logic [PW-1:0] on_limit;
  logic          lit;

  always_comb begin
    slot_wrap = (slot_cnt_q == SLOT_LAST);
    frame_end = slot_wrap && (digit_q == 2'd3);

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;

    shadow_d = load ? sseg_in : shadow_q;
    // A load landing on the boundary edge goes straight to the display.
    active_d = frame_end ? (load ? sseg_in : shadow_q) : active_q;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    on_limit = (PW'(bright) + PW'(1)) * SUB_P;

    // slot_cnt 0 is kept dark so the previous digit's segments never
    // ghost onto the next anode while both change.
    lit = (slot_cnt_q != '0) &&
          (PW'(slot_cnt_q) < on_limit) &&
          !(blink_phase_q && blink_mask[digit_q]);

    anode_d      = lit ? ~(4'b0001 << digit_q) : 4'hF;
    sout_d       = lit ? active_q[{digit_q, 3'b000} +: 8] : 8'hFF;
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt_q    <= '0;
      digit_q       <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shadow_q      <= 32'hFFFF_FFFF;
      active_q      <= 32'hFFFF_FFFF;
      anode_q       <= 4'hF;
      sout_q        <= 8'hFF;
      frame_tick_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      anode_q       <= anode_d;
      sout_q        <= sout_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign sout       = sout_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - scoreboard bench for sseg_scan_driver
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sseg_in = 32'h0;
  logic        load = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [2:0]  bright = 3'd7;

  logic [3:0] anode_a, anode_b, anode_c;
  logic [7:0] sout_a, sout_b, sout_c;
  logic       tick_a, tick_b, tick_c;

  always #5 clk = ~clk;

  sseg_scan_driver #(.REFRESH_DIV(8), .BLINK_FRAMES(128)) dut_a (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .load(load), .blink_mask(blink_mask),
    .bright(bright), .anode(anode_a), .sout(sout_a), .frame_tick(tick_a));

  sseg_scan_driver #(.REFRESH_DIV(16), .BLINK_FRAMES(128)) dut_b (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .load(load), .blink_mask(blink_mask),
    .bright(bright), .anode(anode_b), .sout(sout_b), .frame_tick(tick_b));

  sseg_scan_driver #(.REFRESH_DIV(8), .BLINK_FRAMES(2)) dut_c (
    .clk(clk), .rst(rst), .sseg_in(sseg_in), .load(load), .blink_mask(blink_mask),
    .bright(bright), .anode(anode_c), .sout(sout_c), .frame_tick(tick_c));

  int sel = 0;
  int rd  = 8;
  int bf  = 128;
  logic [3:0] anode_s;
  logic [7:0] sout_s;
  logic       tick_s;

  always_comb begin
    anode_s = anode_a;
    sout_s  = sout_a;
    tick_s  = tick_a;
    case (sel)
      1: begin anode_s = anode_b; sout_s = sout_b; tick_s = tick_b; end
      2: begin anode_s = anode_c; sout_s = sout_c; tick_s = tick_c; end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] anode;
    logic [7:0] sout;
    logic       tick;
    int         k;
  } exp_t;
  exp_t sb[$];

  logic [31:0] shadow_m, active_m;
  int          cnt_m;
  bit          phase_m;
  int          k;

  // Expected outputs after edge k, derived from cycle index arithmetic.
  task automatic push_expected();
    exp_t e;
    int slot, dig;
    bit lit;
    slot = (k - 1) % rd;
    dig  = ((k - 1) / rd) % 4;
    lit  = (slot != 0) && (slot < (int'(bright) + 1) * (rd / 8)) &&
           !(phase_m && blink_mask[dig]);
    e.anode = lit ? ~(4'b0001 << dig) : 4'hF;
    e.sout  = lit ? active_m[dig*8 +: 8] : 8'hFF;
    e.tick  = (k % (4 * rd)) == 0;
    e.k     = k;
    sb.push_back(e);
  endtask

  task automatic model_edge();
    if (k % (4 * rd) == 0) begin
      active_m = load ? sseg_in : shadow_m;
      cnt_m++;
      if (cnt_m == bf) begin
        cnt_m   = 0;
        phase_m = ~phase_m;
      end
    end
    if (load) shadow_m = sseg_in;
  endtask

  task automatic step();
    push_expected();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    shadow_m = 32'hFFFF_FFFF;
    active_m = 32'hFFFF_FFFF;
    cnt_m    = 0;
    phase_m  = 1'b0;
    k        = 1;
    rst      = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (anode_a !== 4'hF || anode_b !== 4'hF || anode_c !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_anode got %h %h %h want F", anode_a, anode_b, anode_c);
    end
    n_cmp++;
    if (sout_a !== 8'hFF || sout_b !== 8'hFF || sout_c !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_sout got %h %h %h want FF", sout_a, sout_b, sout_c);
    end
    n_cmp++;
    if (tick_a !== 1'b0 || tick_b !== 1'b0 || tick_c !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tick got %b %b %b want 0", tick_a, tick_b, tick_c);
    end
  endtask

  // Scan order, guard cycles, frame tick and mid-frame load.
  task automatic test_scan();
    exp_t e;
    sel = 0; rd = 8; bf = 128; bright = 3'd7; blink_mask = 4'h0;
    do_reset();
    for (int i = 0; i < 110; i++) begin
      load    = (k == 1) || (k == 40);
      sseg_in = (k == 40) ? 32'hAABBCCDD : 32'h11223344;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL scan k=%0d anode=%h want %h sout=%h want %h tick=%b want %b",
                 e.k, anode_s, e.anode, sout_s, e.sout, tick_s, e.tick);
      end
      n_cmp++;
      if ($countones(~anode_s) > 1) begin
        n_bad++;
        $display("FAIL onehot k=%0d anode=%h want at most one low bit", e.k, anode_s);
      end
      if (e.k == 34) begin
        n_cmp++;
        if (anode_s !== 4'hE || sout_s !== 8'h44) begin
          n_bad++;
          $display("FAIL scan_first k=34 anode=%h sout=%h want E 44", anode_s, sout_s);
        end
      end
      if (e.k == 74) begin
        n_cmp++;
        if (anode_s !== 4'hD || sout_s !== 8'hCC) begin
          n_bad++;
          $display("FAIL scan_reload k=74 anode=%h sout=%h want D CC", anode_s, sout_s);
        end
      end
    end
    load = 1'b0;
  endtask

  // Load on the boundary edge must bypass the shadow.
  task automatic test_bypass();
    exp_t e;
    sel = 0; rd = 8; bf = 128; bright = 3'd7; blink_mask = 4'h0;
    do_reset();
    for (int i = 0; i < 48; i++) begin
      load    = (k == 32);
      sseg_in = 32'h01020304;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL bypass k=%0d anode=%h want %h sout=%h want %h tick=%b want %b",
                 e.k, anode_s, e.anode, sout_s, e.sout, tick_s, e.tick);
      end
      if (e.k == 34) begin
        n_cmp++;
        if (sout_s !== 8'h04) begin
          n_bad++;
          $display("FAIL bypass_direct k=34 sout=%h want 04", sout_s);
        end
      end
    end
    load = 1'b0;
  endtask

  // Brightness window, including live changes mid-slot.
  task automatic test_bright();
    exp_t e;
    int lit1, lit0;
    lit1 = 0; lit0 = 0;
    sel = 1; rd = 16; bf = 128; blink_mask = 4'h0; bright = 3'd1;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      load    = (k == 1);
      sseg_in = 32'h5A6B7C8D;
      if (k <= 128)                 bright = 3'd1;
      else if (k <= 192)            bright = 3'd0;
      else if (k >= 230 && k < 234) bright = 3'd3;
      else                          bright = 3'd7;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL bright k=%0d anode=%h want %h sout=%h want %h tick=%b want %b",
                 e.k, anode_s, e.anode, sout_s, e.sout, tick_s, e.tick);
      end
      if (e.k >= 65 && e.k <= 80 && anode_s !== 4'hF) lit1++;
      if (e.k >= 129 && e.k <= 144 && anode_s !== 4'hF) lit0++;
    end
    n_cmp++;
    if (lit1 !== 3) begin
      n_bad++;
      $display("FAIL bright1_count lit=%0d want 3", lit1);
    end
    n_cmp++;
    if (lit0 !== 1) begin
      n_bad++;
      $display("FAIL bright0_count lit=%0d want 1", lit0);
    end
    bright = 3'd7;
    load   = 1'b0;
  endtask

  task automatic test_blink();
    exp_t e;
    sel = 2; rd = 8; bf = 2; bright = 3'd7; blink_mask = 4'b0101;
    do_reset();
    for (int i = 0; i < 270; i++) begin
      load    = (k == 1);
      sseg_in = 32'h12345678;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL blink k=%0d anode=%h want %h sout=%h want %h tick=%b want %b",
                 e.k, anode_s, e.anode, sout_s, e.sout, tick_s, e.tick);
      end
      if (e.k == 66 || e.k == 130) begin
        n_cmp++;
        if (anode_s !== ((e.k == 66) ? 4'hF : 4'hE)) begin
          n_bad++;
          $display("FAIL blink_digit0 k=%0d anode=%h want %h", e.k, anode_s,
                   (e.k == 66) ? 4'hF : 4'hE);
        end
      end
      if (e.k == 74) begin
        n_cmp++;
        if (anode_s !== 4'hD || sout_s !== 8'h56) begin
          n_bad++;
          $display("FAIL blink_digit1 k=74 anode=%h sout=%h want D 56", anode_s, sout_s);
        end
      end
    end
    blink_mask = 4'h0;
    load       = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    sel = 0; rd = 8; bf = 128; bright = 3'd7; blink_mask = 4'h0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      load    = (k == 1);
      sseg_in = 32'h11223344;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL pre_rst k=%0d anode=%h want %h sout=%h want %h", e.k,
                 anode_s, e.anode, sout_s, e.sout);
      end
    end
    load = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (anode_s !== 4'hF || sout_s !== 8'hFF || tick_s !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst anode=%h sout=%h tick=%b want F FF 0", anode_s, sout_s, tick_s);
    end
    do_reset();
    for (int i = 0; i < 75; i++) begin
      load    = (k == 41);
      sseg_in = 32'h11223344;
      step();
      e = sb.pop_front();
      n_cmp++;
      if (anode_s !== e.anode || sout_s !== e.sout || tick_s !== e.tick) begin
        n_bad++;
        $display("FAIL post_rst k=%0d anode=%h want %h sout=%h want %h tick=%b want %b",
                 e.k, anode_s, e.anode, sout_s, e.sout, tick_s, e.tick);
      end
      if (e.k == 34 || e.k == 66) begin
        n_cmp++;
        if (sout_s !== ((e.k == 34) ? 8'hFF : 8'h44)) begin
          n_bad++;
          $display("FAIL post_rst_direct k=%0d sout=%h want %h", e.k, sout_s,
                   (e.k == 34) ? 8'hFF : 8'h44);
        end
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bypass();
    test_bright();
    test_blink();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
